time_counter: RTL and testbench
===============================

# time_counter

BCD time-of-day counter that produces the hours/minutes digit bus (`out_Hh`, `out_Hl`, `out_mh`, `out_ml`) consumed by the alarm comparator. It divides the system clock down to a 1 s tick and counts seconds, minutes and hours in 24-hour BCD. Two push-buttons set the current time. It is the stage directly upstream of the alarm-match logic.

## Interface
- `DIV`, 50000000, system clock cycles per second tick; ≥2.
- `clk_1`  input  1  system clock; all state changes on its rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `run`  input  1  count enable; level, synchronous.
- `set_h`  input  1  hour-set button; raw and asynchronous.
- `set_m`  input  1  minute-set button; raw and asynchronous.
- `out_Hh`  output  4  hours tens, BCD 0–2.
- `out_Hl`  output  4  hours units, BCD 0–9 (0–3 when `out_Hh`=2).
- `out_mh`  output  4  minutes tens, BCD 0–5.
- `out_ml`  output  4  minutes units, BCD 0–9.
- `out_sh`  output  4  seconds tens, BCD 0–5.
- `out_sl`  output  4  seconds units, BCD 0–9.
- `sec_pulse`  output  1  one-cycle pulse on each accepted second tick.
- `chime`  output  1  one-cycle pulse at the top of each hour; requires the macro in Configuration.

## Operation
- Reset: every digit is 0 (00:00:00), the prescaler is 0, the synchronizer and edge registers are 0, and `sec_pulse` and `chime` are 0.
- Prescaler:
  - Counts 0..DIV-1 while `run`=1.
  - Raises the internal `tick` in the cycle where the count equals DIV-1, then wraps to 0.
  - `run`=0 holds the prescaler at 0 and raises no ticks.
- `set_h` and `set_m` each pass through a 2-FF synchronizer. A rising-edge detect on the synchronized signal gives a one-cycle `inc_h` / `inc_m`.
- On `tick`, with no set event in that cycle:
  - Seconds increment. 59 wraps to 00 and carries to minutes.
  - Minutes 59 wraps to 00 and carries to hours.
  - Hours 23 wraps to 00.
  - Each digit wraps independently at its BCD limit: units 9→0 with a carry to the tens digit.
- `inc_h`: hours advance by one (23→00). Minutes and seconds are unchanged. There is no carry.
- `inc_m`: minutes advance by one (59→00) with no carry into hours. Seconds clear to 00.
- Simultaneous events:
  - Any set event in a cycle discards that cycle's `tick`. The prescaler still wraps normally.
  - `inc_h` and `inc_m` in the same cycle both apply.
- Set events are accepted regardless of `run`.
- Digit values outside their legal range cannot be reached and need no handling.

## Timing
- Digit outputs are registered and update in the cycle after `tick`.
- `sec_pulse` is registered and is high for exactly the same cycle in which the new seconds value first appears.
- Button path latency: `set_*` rising edge → synchronizer 2 cycles → edge detect → the digit changes on the 3rd rising `clk_1` edge after the input is stable high.
- A button held high produces exactly one increment. A new increment needs a low level of at least 2 cycles, then a new rising edge.
- Asserting `rst_n` low mid-count clears all state immediately. Counting resumes from 00:00:00, with the prescaler at 0, on the first edge after release.

## Configuration
- `HOURLY_CHIME_EN` defined:
  - `chime` pulses high for one cycle, coincident with `sec_pulse`, when a tick carries the time from hh:59:59 to (hh+1):00:00. This includes 23:59:59→00:00:00.
  - Set events never raise `chime`.
- Undefined: `chime` is tied to 0 and no chime logic is generated.

## Test plan
- Reset and count, DIV=4, `run`=1: release reset → `sec_pulse` every 4 cycles; after 60 ticks the time reads 00:01:00.
- Full rollover: preset 23:59:59 via buttons and ticks, then one tick → 00:00:00. `chime`=1 for one cycle with the macro defined; 0 without it.
- Set behaviour: at 12:59:30, pulse `set_m` → 12:00:00, with no hour carry. Pulse `set_h` ×12 from 12 → 00.
- Collision: assert `set_m` so that `inc_m` lands on the `tick` cycle at 05:10:58 → 05:11:00 and no `sec_pulse` that cycle. The next tick arrives DIV cycles after the previous one.
- Hold and debounce: hold `set_h` high for 100 cycles → exactly one hour increment, 3 cycles after the rise. `run`=0 for 50 cycles → digits frozen and the prescaler held at 0.
- Async reset mid-count: pull `rst_n` low between clock edges at 07:33:21 → all outputs read 0 before the next edge.

Source files
------------

// File: rtl/time_counter_if.sv
// Control and display bus of the BCD time-of-day counter.
// The master side drives the run level and the two raw set buttons.
interface time_counter_if;
  logic       run;
  logic       set_h;
  logic       set_m;
  logic [3:0] out_Hh;
  logic [3:0] out_Hl;
  logic [3:0] out_mh;
  logic [3:0] out_ml;
  logic [3:0] out_sh;
  logic [3:0] out_sl;
  logic       sec_pulse;
  logic       chime;

  modport master (
    output run, set_h, set_m,
    input  out_Hh, out_Hl, out_mh, out_ml, out_sh, out_sl, sec_pulse, chime
  );

  modport slave (
    input  run, set_h, set_m,
    output out_Hh, out_Hl, out_mh, out_ml, out_sh, out_sl, sec_pulse, chime
  );
endinterface

// File: rtl/time_counter.sv
// 24-hour BCD time-of-day counter with a 1 s prescaler and hour/minute set buttons.
// Define HOURLY_CHIME_EN to build the top-of-hour chime pulse; otherwise chime is tied low.
module time_counter #(
  parameter int DIV = 50000000
) (
  input  logic          clk_1,
  input  logic          rst_n,
  time_counter_if.slave bus
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] PRE_LAST = CW'(DIV - 1);

  // Each time field is held as a packed BCD pair {tens, units}.
  logic [7:0]    hrs, mins, secs;
  logic [7:0]    hrs_next, mins_next, secs_next;
  logic [CW-1:0] pre_cnt;
  logic          tick;
  logic [1:0]    sync_h, sync_m;
  logic          prev_h, prev_m;
  logic          inc_h, inc_m;
  logic          accept;
  logic          sec_pulse_q;

  function automatic logic [7:0] inc_min_sec(input logic [7:0] v);
    if (v[3:0] != 4'd9)      return {v[7:4], v[3:0] + 4'd1};
    else if (v[7:4] != 4'd5) return {v[7:4] + 4'd1, 4'd0};
    else                     return 8'h00;
  endfunction

  function automatic logic [7:0] inc_hour(input logic [7:0] v);
    if (v == 8'h23)          return 8'h00;
    else if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    else                     return {v[7:4], v[3:0] + 4'd1};
  endfunction

  assign tick = bus.run && (pre_cnt == PRE_LAST);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_1 or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt <= '0;
    end else if (!bus.run) begin
      pre_cnt <= '0;
    end else if (pre_cnt == PRE_LAST) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + 1'b1;
    end
  end

  // Buttons are asynchronous: two flops for metastability, a third for the rising-edge detect.
  always_ff @(posedge clk_1 or negedge rst_n) begin
    if (!rst_n) begin
      sync_h <= '0;
      sync_m <= '0;
      prev_h <= 1'b0;
      prev_m <= 1'b0;
    end else begin
      sync_h <= {sync_h[0], bus.set_h};
      sync_m <= {sync_m[0], bus.set_m};
      prev_h <= sync_h[1];
      prev_m <= sync_m[1];
    end
  end

  assign inc_h  = sync_h[1] & ~prev_h;
  assign inc_m  = sync_m[1] & ~prev_m;
  assign accept = tick & ~(inc_h | inc_m);

  // NOTE: every always_comb output gets its default first so no path can infer a latch.
  always_comb begin
    hrs_next  = hrs;
    mins_next = mins;
    secs_next = secs;
    if (accept) begin
      secs_next = inc_min_sec(secs);
      if (secs == 8'h59) begin
        mins_next = inc_min_sec(mins);
        if (mins == 8'h59) hrs_next = inc_hour(hrs);
      end
    end
    if (inc_m) begin
      mins_next = inc_min_sec(mins);
      secs_next = 8'h00;
    end
    if (inc_h) hrs_next = inc_hour(hrs);
  end

  always_ff @(posedge clk_1 or negedge rst_n) begin
    if (!rst_n) begin
      hrs         <= 8'h00;
      mins        <= 8'h00;
      secs        <= 8'h00;
      sec_pulse_q <= 1'b0;
    end else begin
      hrs         <= hrs_next;
      mins        <= mins_next;
      secs        <= secs_next;
      sec_pulse_q <= accept;
    end
  end

  assign bus.out_Hh    = hrs[7:4];
  assign bus.out_Hl    = hrs[3:0];
  assign bus.out_mh    = mins[7:4];
  assign bus.out_ml    = mins[3:0];
  assign bus.out_sh    = secs[7:4];
  assign bus.out_sl    = secs[3:0];
  assign bus.sec_pulse = sec_pulse_q;

`ifdef HOURLY_CHIME_EN
  logic chime_q;
  logic top_of_hour;

  // Only a counted tick can cross an hour boundary; set events suppress the tick.
  assign top_of_hour = accept && (secs == 8'h59) && (mins == 8'h59);

  always_ff @(posedge clk_1 or negedge rst_n) begin
    if (!rst_n) chime_q <= 1'b0;
    else        chime_q <= top_of_hour;
  end

  assign bus.chime = chime_q;
`else
  assign bus.chime = 1'b0;
`endif

endmodule

// File: tb/tb_time_counter.sv
// Directed bench for time_counter with DIV=4; outputs are sampled on the falling clock edge.
// Time is read as a 24-bit BCD word {Hh,Hl,mh,ml,sh,sl} so 24'h125930 means 12:59:30.
module tb_time_counter;

  logic clk_1;
  logic rst_n;
  int   vectors;
  int   miscompares;
  logic exp_chime;

  time_counter_if bus ();

  time_counter #(.DIV(4)) dut (
    .clk_1 (clk_1),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk_1 = 1'b0;
  always #5 clk_1 = ~clk_1;

  function automatic logic [23:0] now_time();
    return {bus.out_Hh, bus.out_Hl, bus.out_mh, bus.out_ml, bus.out_sh, bus.out_sl};
  endfunction

  task automatic apply_reset();
    @(negedge clk_1);
    rst_n     = 1'b0;
    bus.run   = 1'b0;
    bus.set_h = 1'b0;
    bus.set_m = 1'b0;
    repeat (2) @(negedge clk_1);
    rst_n = 1'b1;
  endtask

  task automatic press_h(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_1);
      bus.set_h = 1'b1;
      repeat (3) @(negedge clk_1);
      bus.set_h = 1'b0;
      repeat (3) @(negedge clk_1);
    end
  endtask

  task automatic press_m(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_1);
      bus.set_m = 1'b1;
      repeat (3) @(negedge clk_1);
      bus.set_m = 1'b0;
      repeat (3) @(negedge clk_1);
    end
  endtask

  // Returns at the falling edge where sec_pulse is seen high; a timeout counts as a miscompare.
  task automatic wait_pulses(input int n);
    for (int p = 0; p < n; p++) begin
      bit got;
      got = 1'b0;
      for (int i = 0; i < 8 && !got; i++) begin
        @(negedge clk_1);
        if (bus.sec_pulse) got = 1'b1;
      end
      if (!got) begin
        vectors++;
        miscompares++;
        $display("FAIL sec_pulse_timeout: pulse %0d not seen within 8 cycles", p);
      end
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    bus.run   = 1'b0;
    bus.set_h = 1'b0;
    bus.set_m = 1'b0;
    @(negedge clk_1);
    vectors++;
    if (now_time() !== 24'h000000) begin
      miscompares++;
      $display("FAIL reset_time: got %h expected 000000", now_time());
    end
    vectors++;
    if ({bus.sec_pulse, bus.chime} !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_pulses: got %b expected 00", {bus.sec_pulse, bus.chime});
    end
    @(negedge clk_1);
    rst_n = 1'b1;
  endtask

  task automatic test_count();
    int pulses, chimes, first_k;
    apply_reset();
    bus.run = 1'b1;
    pulses  = 0;
    chimes  = 0;
    first_k = 0;
    for (int k = 1; k <= 240; k++) begin
      @(negedge clk_1);
      if (bus.sec_pulse) begin
        pulses++;
        if (first_k == 0) first_k = k;
      end
      if (bus.chime) chimes++;
    end
    bus.run = 1'b0;
    vectors++;
    if (first_k !== 4) begin
      miscompares++;
      $display("FAIL first_pulse_cycle: got %0d expected 4", first_k);
    end
    vectors++;
    if (pulses !== 60) begin
      miscompares++;
      $display("FAIL pulse_count: got %0d expected 60", pulses);
    end
    vectors++;
    if (now_time() !== 24'h000100) begin
      miscompares++;
      $display("FAIL count_60_ticks: got %h expected 000100", now_time());
    end
    vectors++;
    if (chimes !== 0) begin
      miscompares++;
      $display("FAIL chime_mid_hour: got %0d expected 0", chimes);
    end
  endtask

  task automatic test_rollover();
    apply_reset();
    press_h(23);
    press_m(59);
    bus.run = 1'b1;
    wait_pulses(59);
    vectors++;
    if (now_time() !== 24'h235959) begin
      miscompares++;
      $display("FAIL preset_235959: got %h expected 235959", now_time());
    end
    vectors++;
    if (bus.chime !== 1'b0) begin
      miscompares++;
      $display("FAIL chime_before_rollover: got %b expected 0", bus.chime);
    end
    wait_pulses(1);
    bus.run = 1'b0;
    vectors++;
    if (now_time() !== 24'h000000) begin
      miscompares++;
      $display("FAIL rollover_time: got %h expected 000000", now_time());
    end
    vectors++;
    if (bus.chime !== exp_chime) begin
      miscompares++;
      $display("FAIL rollover_chime: got %b expected %b", bus.chime, exp_chime);
    end
    @(negedge clk_1);
    vectors++;
    if (bus.chime !== 1'b0) begin
      miscompares++;
      $display("FAIL chime_width: got %b expected 0", bus.chime);
    end
  endtask

  task automatic test_set();
    apply_reset();
    press_h(12);
    press_m(59);
    bus.run = 1'b1;
    wait_pulses(30);
    bus.run = 1'b0;
    vectors++;
    if (now_time() !== 24'h125930) begin
      miscompares++;
      $display("FAIL preset_125930: got %h expected 125930", now_time());
    end
    press_m(1);
    vectors++;
    if (now_time() !== 24'h120000) begin
      miscompares++;
      $display("FAIL set_m_no_carry: got %h expected 120000", now_time());
    end
    press_h(1);
    vectors++;
    if (now_time() !== 24'h130000) begin
      miscompares++;
      $display("FAIL set_h_once: got %h expected 130000", now_time());
    end
    press_h(11);
    vectors++;
    if (now_time() !== 24'h000000) begin
      miscompares++;
      $display("FAIL set_h_wrap: got %h expected 000000", now_time());
    end
  endtask

  task automatic test_back_to_back();
    bus.run = 1'b1;
    wait_pulses(5);
    bus.run = 1'b0;
    @(negedge clk_1);
    bus.set_h = 1'b1;
    bus.set_m = 1'b1;
    repeat (3) @(negedge clk_1);
    bus.set_h = 1'b0;
    bus.set_m = 1'b0;
    vectors++;
    if (now_time() !== 24'h010100) begin
      miscompares++;
      $display("FAIL both_sets: got %h expected 010100", now_time());
    end
    repeat (3) @(negedge clk_1);
  endtask

  task automatic test_collision();
    apply_reset();
    press_h(5);
    press_m(10);
    bus.run = 1'b1;
    wait_pulses(58);
    vectors++;
    if (now_time() !== 24'h051058) begin
      miscompares++;
      $display("FAIL preset_051058: got %h expected 051058", now_time());
    end
    // inc_m is then high during the fourth cycle, which is also the tick cycle.
    @(negedge clk_1);
    bus.set_m = 1'b1;
    repeat (3) @(negedge clk_1);
    vectors++;
    if ({now_time(), bus.sec_pulse} !== {24'h051100, 1'b0}) begin
      miscompares++;
      $display("FAIL collision: got %h pulse %b expected 051100 pulse 0", now_time(), bus.sec_pulse);
    end
    bus.set_m = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk_1);
      vectors++;
      if (bus.sec_pulse !== (i == 4)) begin
        miscompares++;
        $display("FAIL post_collision_pulse: cycle %0d got %b expected %b", i, bus.sec_pulse, (i == 4));
      end
    end
    vectors++;
    if (now_time() !== 24'h051101) begin
      miscompares++;
      $display("FAIL post_collision_time: got %h expected 051101", now_time());
    end
  endtask

  task automatic test_hold();
    bus.run = 1'b0;
    @(negedge clk_1);
    bus.set_h = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk_1);
      vectors++;
      if (now_time() !== ((i == 3) ? 24'h061101 : 24'h051101)) begin
        miscompares++;
        $display("FAIL hold_latency: cycle %0d got %h", i, now_time());
      end
    end
    repeat (97) @(negedge clk_1);
    bus.set_h = 1'b0;
    vectors++;
    if (now_time() !== 24'h061101) begin
      miscompares++;
      $display("FAIL hold_single_inc: got %h expected 061101", now_time());
    end
    repeat (3) @(negedge clk_1);
    press_h(1);
    vectors++;
    if (now_time() !== 24'h071101) begin
      miscompares++;
      $display("FAIL repress: got %h expected 071101", now_time());
    end
  endtask

  task automatic test_run_freeze();
    int pulses;
    bus.run = 1'b1;
    wait_pulses(1);
    repeat (2) @(negedge clk_1);
    bus.run = 1'b0;
    pulses  = 0;
    repeat (50) begin
      @(negedge clk_1);
      if (bus.sec_pulse) pulses++;
    end
    vectors++;
    if ({now_time(), 8'(pulses)} !== {24'h071102, 8'd0}) begin
      miscompares++;
      $display("FAIL freeze: got %h pulses %0d expected 071102 pulses 0", now_time(), pulses);
    end
    bus.run = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk_1);
      vectors++;
      if (bus.sec_pulse !== (i == 4)) begin
        miscompares++;
        $display("FAIL resume_pulse: cycle %0d got %b expected %b", i, bus.sec_pulse, (i == 4));
      end
    end
    bus.run = 1'b0;
    vectors++;
    if (now_time() !== 24'h071103) begin
      miscompares++;
      $display("FAIL resume_time: got %h expected 071103", now_time());
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    press_h(7);
    press_m(33);
    bus.run = 1'b1;
    wait_pulses(21);
    vectors++;
    if (now_time() !== 24'h073321) begin
      miscompares++;
      $display("FAIL preset_073321: got %h expected 073321", now_time());
    end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({now_time(), bus.sec_pulse, bus.chime} !== 26'd0) begin
      miscompares++;
      $display("FAIL async_reset: got %h pulse %b chime %b expected all 0", now_time(), bus.sec_pulse, bus.chime);
    end
    @(negedge clk_1);
    rst_n = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk_1);
      vectors++;
      if (bus.sec_pulse !== (i == 4)) begin
        miscompares++;
        $display("FAIL restart_pulse: cycle %0d got %b expected %b", i, bus.sec_pulse, (i == 4));
      end
    end
    vectors++;
    if (now_time() !== 24'h000001) begin
      miscompares++;
      $display("FAIL restart_time: got %h expected 000001", now_time());
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
`ifdef HOURLY_CHIME_EN
    exp_chime = 1'b1;
`else
    exp_chime = 1'b0;
`endif
    test_reset();
    test_count();
    test_rollover();
    test_set();
    test_back_to_back();
    test_collision();
    test_hold();
    test_run_freeze();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
